// File: rtl/sensor_pattern_gen.sv
// Image-sensor emulator: divided pixel clock, frame/line timing, test patterns.
// Ports: sys_clk/sys_rst_n, enable/mode/fixed_val in; pix_clk/pix_data/valids/frame_done/frame_cnt out.
module sensor_pattern_gen #(
  parameter int DATA_W   = 8,
  parameter int PCLK_DIV = 4,
  parameter int H_ACTIVE = 100,
  parameter int H_BLANK  = 20,
  parameter int V_ACTIVE = 20,
  parameter int V_BLANK  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fixed_val,
  output logic              pix_clk,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_valid,
  output logic              line_valid,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int HT   = H_ACTIVE + H_BLANK;
  localparam int VT   = V_ACTIVE + V_BLANK;
  localparam int HALF = PCLK_DIV / 2;
  localparam int DW   = $clog2(PCLK_DIV);
  // at least 4 bits so the checkerboard can always pick bit 3
  localparam int HW   = ($clog2(HT) < 4) ? 4 : $clog2(HT);
  localparam int VW   = ($clog2(VT) < 4) ? 4 : $clog2(VT);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, HBLANK, VBLANK
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]     div_cnt;
  logic              tick;
  logic [HW-1:0]     h_cnt, h_inc;
  logic [VW-1:0]     v_cnt, v_inc;
  logic              h_wrap, v_last, act_last;
  logic              start, done;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fix_q, run_cnt, pattern;

  assign tick = (div_cnt == DW'(HALF - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      pix_clk <= 1'b0;
    end else begin
      if (div_cnt == DW'(PCLK_DIV - 1)) begin
        div_cnt <= '0;
        pix_clk <= 1'b1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
        if (tick) pix_clk <= 1'b0;
      end
    end
  end

  assign h_wrap   = (h_cnt == HW'(HT - 1));
  assign h_inc    = h_wrap ? '0 : h_cnt + HW'(1);
  assign v_last   = (v_cnt == VW'(VT - 1));
  assign v_inc    = v_last ? '0 : v_cnt + VW'(1);
  assign act_last = (v_cnt == VW'(V_ACTIVE - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state_nx = ACTIVE;
            start    = 1'b1;
          end
        end
        ACTIVE: begin
          if (h_inc == HW'(H_ACTIVE)) state_nx = HBLANK;
        end
        HBLANK: begin
          if (h_wrap) state_nx = act_last ? VBLANK : ACTIVE;
        end
        VBLANK: begin
          if (h_wrap && v_last) begin
            done = 1'b1;
            if (enable) begin
              state_nx = ACTIVE;
              start    = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // leaving VBLANK wraps h/v to 0 on its own, so IDLE always sits at h=v=0
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      run_cnt <= '0;
      mode_q  <= '0;
      fix_q   <= '0;
    end else if (start) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      run_cnt <= '0;
      mode_q  <= mode;
      fix_q   <= fixed_val;
    end else if (tick && state != IDLE) begin
      h_cnt <= h_inc;
      if (h_wrap) v_cnt <= v_inc;
      if (state == ACTIVE) run_cnt <= run_cnt + DATA_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= done;
      if (done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    pattern = '0;
    unique case (mode_q)
      2'd0: pattern = run_cnt;
      2'd1: pattern = DATA_W'(h_cnt);
      2'd2: pattern = (h_cnt[3] ^ v_cnt[3]) ? '1 : '0;
      default: pattern = fix_q;
    endcase
  end

  // frame_valid ends with the last active pixel of the last line
  assign line_valid  = (state == ACTIVE);
  assign frame_valid = line_valid || (state == HBLANK && !act_last);
  assign pix_data    = line_valid ? pattern : '0;

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Directed bench for sensor_pattern_gen with reduced frame geometry.
// Checks reset, timing, patterns, enable gating and mid-line reset.
`timescale 1ns/1ps
module tb_sensor_pattern_gen;

  localparam int DW    = 8;
  localparam int PDIV  = 4;
  localparam int HA    = 24;
  localparam int HB    = 4;
  localparam int VA    = 12;
  localparam int VB    = 2;
  localparam int LINE  = (HA + HB) * PDIV;
  localparam int FRAME = (VA + VB) * LINE;
  localparam int NV    = 21;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] fixed_val;
  logic          pix_clk;
  logic [DW-1:0] pix_data;
  logic          frame_valid;
  logic          line_valid;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  sensor_pattern_gen #(
    .DATA_W(DW), .PCLK_DIV(PDIV),
    .H_ACTIVE(HA), .H_BLANK(HB),
    .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable(enable),
    .mode(mode),
    .fixed_val(fixed_val),
    .pix_clk(pix_clk),
    .pix_data(pix_data),
    .frame_valid(frame_valid),
    .line_valid(line_valid),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    nchk++;
    if (act == exp_v) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // frame_done pulse counter and blank-data watcher
  int ndone = 0;
  int blank_bad = 0;
  always @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ndone <= 0;
    else if (frame_done) ndone <= ndone + 1;
  end
  always @(negedge sys_clk) begin
    if (sys_rst_n && !line_valid && pix_data != '0)
      blank_bad <= blank_bad + 1;
  end

  // frame capture at pix_clk rising
  logic [DW-1:0] cap [VA][HA];
  int   row = -1, col = 0, rows_seen = 0, cols_seen = 0;
  logic lvq = 1'b0;
  initial begin
    forever begin
      @(posedge pix_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        row = -1; lvq = 1'b0;
      end else if (!frame_valid) begin
        if (row >= 0) begin
          rows_seen = row + 1;
          cols_seen = col;
        end
        row = -1; lvq = 1'b0;
      end else begin
        if (line_valid && !lvq) begin
          row++; col = 0;
        end
        if (line_valid) begin
          if (row >= 0 && row < VA && col < HA) cap[row][col] = pix_data;
          col++;
        end
        lvq = line_valid;
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return pix_clk;
      1: return line_valid;
      2: return frame_valid;
      default: return frame_done;
    endcase
  endfunction

  task automatic measure(input int w, output int hi, output int lo);
    int n;
    hi = 0; lo = 0; n = 0;
    @(negedge sys_clk);
    while (sig(w) && n < 2*FRAME) begin @(negedge sys_clk); n++; end
    n = 0;
    while (!sig(w) && n < 2*FRAME) begin @(negedge sys_clk); n++; end
    while (sig(w) && hi < 2*FRAME) begin @(negedge sys_clk); hi++; end
    while (!sig(w) && lo < 2*FRAME) begin @(negedge sys_clk); lo++; end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 2*FRAME) begin
      @(negedge sys_clk);
      n++;
      if (frame_done) break;
    end
    chk({name, "_seen"}, int'(frame_done), 1);
    #1;
    chk({name, "_cnt"}, int'(frame_cnt), ndone & 16'hFFFF);
  endtask

  // mode/fixed_val are disturbed mid-frame and restored before the
  // next frame starts, so the checked frame also proves the latching
  task automatic run_frame(input logic [1:0] m, input logic [7:0] f);
    mode = m; fixed_val = f;
    wait_done("rf_a");
    repeat (700) @(negedge sys_clk);
    mode = m ^ 2'd1;
    fixed_val = (f == 8'h3C) ? 8'h5A : 8'h3C;
    repeat (600) @(negedge sys_clk);
    mode = m; fixed_val = f;
    wait_done("rf_b");
  endtask

  task automatic start_lat(input string name);
    int lat;
    lat = 0;
    enable = 1'b1;
    while (lat < 20) begin
      @(negedge sys_clk);
      lat++;
      if (line_valid) break;
    end
    chk(name, int'(lat >= 1 && lat <= PDIV), 1);
  endtask

  typedef struct packed {
    logic       fresh;
    logic [1:0] mode;
    logic [7:0] fix;
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vt [NV];

  initial begin
    int hi, lo, bad;
    logic [1:0] pm;
    logic [7:0] pf;

    vt = '{
      '{1'b1, 2'd0, 8'h00, 8'd0,  8'd0,  8'd0},
      '{1'b0, 2'd0, 8'h00, 8'd0,  8'd23, 8'd23},
      '{1'b0, 2'd0, 8'h00, 8'd1,  8'd0,  8'd24},
      '{1'b0, 2'd0, 8'h00, 8'd10, 8'd15, 8'd255},
      '{1'b0, 2'd0, 8'h00, 8'd10, 8'd16, 8'd0},
      '{1'b0, 2'd0, 8'h00, 8'd11, 8'd23, 8'd31},
      '{1'b1, 2'd0, 8'h00, 8'd0,  8'd0,  8'd0},
      '{1'b0, 2'd0, 8'h00, 8'd1,  8'd0,  8'd24},
      '{1'b0, 2'd1, 8'h00, 8'd0,  8'd0,  8'd0},
      '{1'b0, 2'd1, 8'h00, 8'd5,  8'd17, 8'd17},
      '{1'b0, 2'd1, 8'h00, 8'd11, 8'd23, 8'd23},
      '{1'b0, 2'd2, 8'h00, 8'd0,  8'd8,  8'hFF},
      '{1'b0, 2'd2, 8'h00, 8'd0,  8'd7,  8'h00},
      '{1'b0, 2'd2, 8'h00, 8'd8,  8'd8,  8'h00},
      '{1'b0, 2'd2, 8'h00, 8'd8,  8'd3,  8'hFF},
      '{1'b0, 2'd2, 8'h00, 8'd9,  8'd16, 8'hFF},
      '{1'b0, 2'd2, 8'h00, 8'd3,  8'd16, 8'h00},
      '{1'b0, 2'd3, 8'hA5, 8'd0,  8'd0,  8'hA5},
      '{1'b0, 2'd3, 8'hA5, 8'd11, 8'd23, 8'hA5},
      '{1'b0, 2'd3, 8'h3C, 8'd0,  8'd0,  8'h3C},
      '{1'b0, 2'd3, 8'h3C, 8'd6,  8'd12, 8'h3C}
    };

    sys_rst_n = 1'b0; enable = 1'b0;
    mode = 2'd0; fixed_val = 8'h00;
    #25;
    chk("rst_pix_clk", int'(pix_clk), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_lv", int'(line_valid), 0);
    chk("rst_data", int'(pix_data), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_cnt", int'(frame_cnt), 0);

    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("idle_fv", int'(frame_valid), 0);
    chk("idle_lv", int'(line_valid), 0);
    measure(0, hi, lo);
    chk("pclk_hi", hi, PDIV/2);
    chk("pclk_lo", lo, PDIV/2);

    start_lat("first_start_lat");
    measure(1, hi, lo);
    chk("lv_hi", hi, HA*PDIV);
    chk("lv_lo", lo, HB*PDIV);
    wait_done("f1");
    chk("cnt_is_1", int'(frame_cnt), 1);
    wait_done("f2");
    chk("cnt_is_2", int'(frame_cnt), 2);
    measure(2, hi, lo);
    chk("fv_hi", hi, (VA-1)*LINE + HA*PDIV);
    chk("fv_lo", lo, VB*LINE + HB*PDIV);
    measure(3, hi, lo);
    chk("fd_width", hi, 1);
    chk("fd_period", hi + lo, FRAME);

    pm = 2'd0; pf = 8'h00;
    for (int i = 0; i < NV; i++) begin
      if (i == 0 || vt[i].fresh || vt[i].mode != pm || vt[i].fix != pf) begin
        run_frame(vt[i].mode, vt[i].fix);
        chk("rows", rows_seen, VA);
        chk("cols", cols_seen, HA);
        pm = vt[i].mode; pf = vt[i].fix;
      end
      chk($sformatf("pix_m%0d_y%0d_x%0d", vt[i].mode, vt[i].y, vt[i].x),
          int'(cap[vt[i].y][vt[i].x]), int'(vt[i].exp_d));
    end

    // drop enable mid-frame: frame finishes, then idle
    wait_done("en_a");
    repeat (5*LINE) @(negedge sys_clk);
    enable = 1'b0;
    wait_done("en_last");
    hi = int'(frame_cnt);
    bad = 0;
    repeat (3*LINE) begin
      @(negedge sys_clk);
      if (frame_valid || line_valid || frame_done) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_cnt_hold", int'(frame_cnt), hi);
    start_lat("restart_lat");

    // asynchronous reset in the middle of a line
    mode = 2'd1;
    wait_done("pre_rst");
    bad = 0;
    while (!line_valid && bad < 2*FRAME) begin @(negedge sys_clk); bad++; end
    repeat (10) @(negedge sys_clk);
    bad = 0;
    while (!pix_clk && bad < 8) begin @(negedge sys_clk); bad++; end
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_pix_clk", int'(pix_clk), 0);
    chk("arst_fv", int'(frame_valid), 0);
    chk("arst_lv", int'(line_valid), 0);
    chk("arst_data", int'(pix_data), 0);
    chk("arst_cnt", int'(frame_cnt), 0);
    repeat (5) @(negedge sys_clk);
    chk("arst_hold_pclk", int'(pix_clk), 0);
    sys_rst_n = 1'b1;
    #1;
    chk("post_rst_cnt", int'(frame_cnt), 0);
    measure(0, hi, lo);
    chk("post_rst_pclk", hi + lo, PDIV);
    wait_done("post_rst");
    chk("post_rst_cnt1", int'(frame_cnt), 1);
    chk("post_rst_rows", rows_seen, VA);
    chk("post_rst_p00", int'(cap[0][0]), 0);
    chk("post_rst_p0_23", int'(cap[0][23]), 23);
    chk("post_rst_p11_5", int'(cap[11][5]), 5);

    chk("blank_data_zero", blank_bad, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
